// File: rtl/ucie_ctl_rx_pkg.sv
// ucie_ctl_rx_pkg
// Shared definitions for the UCIe controller RX flit assembler slice:
//   - rx_state_e     : assembler FSM state encoding (IDLE / FILL / FULL)
//   - DEF_NBYTES     : default bytes per FDI input word
//   - DEF_FLIT_WORDS : default words per assembled flit
//   - word_width()   : bits per input word for a given byte count
//   - flit_width()   : bits per flit for a given byte count and word count
package ucie_ctl_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } rx_state_e;

  localparam int DEF_NBYTES     = 4;
  localparam int DEF_FLIT_WORDS = 4;

  function automatic int word_width(input int nbytes);
    return 8 * nbytes;
  endfunction

  function automatic int flit_width(input int nbytes, input int words);
    return 8 * nbytes * words;
  endfunction

endpackage

// File: rtl/ucie_ctl_rx_parity_chk.sv
// ucie_ctl_rx_parity_chk
// Combinational even-parity check over a flit. The top byte of the flit
// carries the XOR of all other bytes, so XOR-ing every byte together gives
// zero for an intact flit; any nonzero result flags an error.
// Only compiled when UCIE_CTL_RX_PARITY_EN is defined, so the default build
// contains no parity logic at all.
// Ports:
//   i_flit : F-bit flit to check (F must be a multiple of 8)
//   o_err  : 1 when the byte-wise XOR of the flit is nonzero
`ifdef UCIE_CTL_RX_PARITY_EN
module ucie_ctl_rx_parity_chk #(
  parameter int F = 128
) (
  input  logic [F-1:0] i_flit,
  output logic         o_err
);

  logic [7:0] byte_xor;

  always_comb begin
    byte_xor = 8'h00;
    for (int i = 0; i < F / 8; i++) begin
      byte_xor = byte_xor ^ i_flit[i*8 +: 8];
    end
    o_err = |byte_xor;
  end

endmodule
`endif

// File: rtl/ucie_ctl_rx_flit_assembler.sv
// ucie_ctl_rx_flit_assembler
// Packs FLIT_WORDS consecutive words from the RX buffer (FDI side) into one
// flit and offers it to the protocol layer over a valid/ready handshake.
// One assembly register plus one output register let a complete flit wait
// in the assembler while the previous one is still held at the output.
// Optional feature: define UCIE_CTL_RX_PARITY_EN to check the flit's
// trailing parity byte; otherwise o_parity_err is tied low.
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_asm_en              : assembler enable (0 returns to IDLE, discards)
//   i_fdi_data/_valid     : input word stream, no backpressure
//   i_overflow_detected   : RX buffer overflow, aborts a partial flit
//   i_flit_ready          : protocol layer accepts the presented flit
//   o_flit_data/_valid    : assembled flit (word 0 in the low bits)
//   o_drop_err            : 1-cycle pulse, word dropped while assembler full
//   o_abort               : 1-cycle pulse, partial flit discarded
//   o_parity_err          : parity error of the presented flit
module ucie_ctl_rx_flit_assembler
  import ucie_ctl_rx_pkg::*;
#(
  parameter int NBYTES     = DEF_NBYTES,
  parameter int FLIT_WORDS = DEF_FLIT_WORDS,
  localparam int W         = word_width(NBYTES),
  localparam int F         = flit_width(NBYTES, FLIT_WORDS),
  localparam int CNT_W     = $clog2(FLIT_WORDS)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_asm_en,
  input  logic [W-1:0] i_fdi_data,
  input  logic         i_fdi_data_valid,
  input  logic         i_overflow_detected,
  input  logic         i_flit_ready,
  output logic [F-1:0] o_flit_data,
  output logic         o_flit_valid,
  output logic         o_drop_err,
  output logic         o_abort,
  output logic         o_parity_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FLIT_WORDS - 1);

  rx_state_e                         state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [FLIT_WORDS-1:0][W-1:0]      asm_q, asm_d;
  logic [F-1:0]                      flit_data_d;
  logic                              flit_valid_d;
  logic                              drop_d;
  logic                              abort_d;
  logic                              load;
  logic [F-1:0]                      load_data;
  logic                              out_free;

  // The output register can take a new flit when empty or when its current
  // flit is being accepted in this same cycle.
  assign out_free = !o_flit_valid || i_flit_ready;

  // Next-state and datapath control. Priority inside FILL/FULL:
  // disable first, then overflow abort, then normal word handling.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    load      = 1'b0;
    load_data = asm_q;
    drop_d    = 1'b0;
    abort_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_asm_en) begin
          state_d = FILL;
        end
      end

      FILL: begin
        if (!i_asm_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (i_overflow_detected &&
                     ((cnt_q != '0) || i_fdi_data_valid)) begin
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (i_fdi_data_valid) begin
          asm_d[cnt_q] = i_fdi_data;
          if (cnt_q == LAST) begin
            if (out_free) begin
              // Bypass the last word straight into the output register so
              // back-to-back flits run without a bubble.
              load      = 1'b1;
              load_data = asm_d;
              cnt_d     = '0;
            end else begin
              state_d = FULL;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      FULL: begin
        if (!i_asm_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          // Every word seen here is lost, including one arriving in the
          // cycle the held flit moves to the output.
          drop_d = i_fdi_data_valid;
          if (out_free) begin
            load      = 1'b1;
            load_data = asm_q;
            cnt_d     = '0;
            state_d   = FILL;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register: holds its flit until accepted, reloads on a new flit.
  always_comb begin
    flit_valid_d = o_flit_valid && !i_flit_ready;
    flit_data_d  = o_flit_data;
    if (load) begin
      flit_valid_d = 1'b1;
      flit_data_d  = load_data;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q        <= '0;
      asm_q        <= '0;
      o_flit_data  <= '0;
      o_flit_valid <= 1'b0;
      o_drop_err   <= 1'b0;
      o_abort      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      o_flit_data  <= flit_data_d;
      o_flit_valid <= flit_valid_d;
      o_drop_err   <= drop_d;
      o_abort      <= abort_d;
    end
  end

`ifdef UCIE_CTL_RX_PARITY_EN
  logic load_parity_err;

  ucie_ctl_rx_parity_chk #(
    .F (F)
  ) u_parity_chk (
    .i_flit (load_data),
    .o_err  (load_parity_err)
  );

  // Parity status is captured with the flit and held alongside it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_parity_err <= 1'b0;
    end else if (load) begin
      o_parity_err <= load_parity_err;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ucie_ctl_rx_flit_assembler.sv
// tb_ucie_ctl_rx_flit_assembler
// Directed bench for ucie_ctl_rx_flit_assembler (default NBYTES=4,
// FLIT_WORDS=4). A table of per-cycle vectors drives the main flows;
// hand-written sequences cover reset mid-flit and, when
// UCIE_CTL_RX_PARITY_EN is defined, the parity byte check.
module tb_ucie_ctl_rx_flit_assembler;

  logic         i_clk;
  logic         i_rst;
  logic         i_asm_en;
  logic [31:0]  i_fdi_data;
  logic         i_fdi_data_valid;
  logic         i_overflow_detected;
  logic         i_flit_ready;
  logic [127:0] o_flit_data;
  logic         o_flit_valid;
  logic         o_drop_err;
  logic         o_abort;
  logic         o_parity_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic         en;
    logic         vld;
    logic [31:0]  data;
    logic         ovf;
    logic         rdy;
    logic         exp_vld;
    logic [127:0] exp_data;
    logic         exp_drop;
    logic         exp_abort;
  } vec_t;

  vec_t vecs[$];

  ucie_ctl_rx_flit_assembler dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_asm_en            (i_asm_en),
    .i_fdi_data          (i_fdi_data),
    .i_fdi_data_valid    (i_fdi_data_valid),
    .i_overflow_detected (i_overflow_detected),
    .i_flit_ready        (i_flit_ready),
    .o_flit_data         (o_flit_data),
    .o_flit_valid        (o_flit_valid),
    .o_drop_err          (o_drop_err),
    .o_abort             (o_abort),
    .o_parity_err        (o_parity_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Expected parity status: nonzero byte-wise XOR over the whole flit.
  function automatic logic flit_parity_bad(input logic [127:0] f);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 16; i++) x = x ^ f[i*8 +: 8];
    return |x;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic en, input logic vld,
                               input logic [31:0] data, input logic ovf,
                               input logic rdy);
    i_asm_en            = en;
    i_fdi_data          = data;
    i_fdi_data_valid    = vld;
    i_overflow_detected = ovf;
    i_flit_ready        = rdy;
    @(posedge i_clk);
    #1;
  endtask

  task automatic add(input logic en, input logic vld, input logic [31:0] d,
                     input logic ovf, input logic rdy, input logic ev,
                     input logic [127:0] ed, input logic edrop,
                     input logic eab);
    vec_t v;
    v.en = en; v.vld = vld; v.data = d; v.ovf = ovf; v.rdy = rdy;
    v.exp_vld = ev; v.exp_data = ed; v.exp_drop = edrop; v.exp_abort = eab;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, ".data"},   o_flit_data,         128'h0);
    checkOutput({tag, ".valid"},  {127'h0, o_flit_valid}, 128'h0);
    checkOutput({tag, ".drop"},   {127'h0, o_drop_err},   128'h0);
    checkOutput({tag, ".abort"},  {127'h0, o_abort},      128'h0);
    checkOutput({tag, ".parity"}, {127'h0, o_parity_err}, 128'h0);
  endtask

  task automatic send_flit(input logic [127:0] f, input logic rdy);
    for (int k = 0; k < 4; k++) applyStimulus(1, 1, f[k*32 +: 32], 0, rdy);
  endtask

  initial begin
    logic [127:0] good;
    logic [127:0] bad;
    logic [7:0]   p;

    i_rst = 1'b1;
    i_asm_en = 0; i_fdi_data = '0; i_fdi_data_valid = 0;
    i_overflow_detected = 0; i_flit_ready = 0;
    repeat (2) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    i_rst = 1'b0;

    // Basic flit, then two back-to-back flits with ready held high.
    add(1,0,32'h0,       0,1, 0,128'h0,0,0);
    add(1,1,32'h11111111,0,1, 0,128'h0,0,0);
    add(1,1,32'h22222222,0,1, 0,128'h0,0,0);
    add(1,1,32'h33333333,0,1, 0,128'h0,0,0);
    add(1,1,32'h44444444,0,1, 1,128'h44444444_33333333_22222222_11111111,0,0);
    add(1,1,32'h55555555,0,1, 0,128'h0,0,0);
    add(1,1,32'h66666666,0,1, 0,128'h0,0,0);
    add(1,1,32'h77777777,0,1, 0,128'h0,0,0);
    add(1,1,32'h88888888,0,1, 1,128'h88888888_77777777_66666666_55555555,0,0);
    add(1,1,32'h99999999,0,1, 0,128'h0,0,0);
    add(1,1,32'hAAAAAAAA,0,1, 0,128'h0,0,0);
    add(1,1,32'hBBBBBBBB,0,1, 0,128'h0,0,0);
    add(1,1,32'hCCCCCCCC,0,1, 1,128'hCCCCCCCC_BBBBBBBB_AAAAAAAA_99999999,0,0);
    add(1,0,32'h0,       0,1, 0,128'h0,0,0);
    // Backpressure: flit D held at output, flit E parked in FULL, drops.
    add(1,1,32'hD0000001,0,0, 0,128'h0,0,0);
    add(1,1,32'hD0000002,0,0, 0,128'h0,0,0);
    add(1,1,32'hD0000003,0,0, 0,128'h0,0,0);
    add(1,1,32'hD0000004,0,0, 1,128'hD0000004_D0000003_D0000002_D0000001,0,0);
    add(1,1,32'hE0000001,0,0, 1,128'hD0000004_D0000003_D0000002_D0000001,0,0);
    add(1,1,32'hE0000002,0,0, 1,128'hD0000004_D0000003_D0000002_D0000001,0,0);
    add(1,1,32'hE0000003,0,0, 1,128'hD0000004_D0000003_D0000002_D0000001,0,0);
    add(1,1,32'hE0000004,0,0, 1,128'hD0000004_D0000003_D0000002_D0000001,0,0);
    add(1,1,32'hF0000009,0,0, 1,128'hD0000004_D0000003_D0000002_D0000001,1,0);
    add(1,1,32'hF000000A,0,1, 1,128'hE0000004_E0000003_E0000002_E0000001,1,0);
    add(1,0,32'h0,       0,1, 0,128'h0,0,0);
    // Overflow after two words, then a clean flit.
    add(1,1,32'h0BAD0001,0,1, 0,128'h0,0,0);
    add(1,1,32'h0BAD0002,0,1, 0,128'h0,0,0);
    add(1,0,32'h0,       1,1, 0,128'h0,0,1);
    add(1,1,32'h12340001,0,1, 0,128'h0,0,0);
    add(1,1,32'h12340002,0,1, 0,128'h0,0,0);
    add(1,1,32'h12340003,0,1, 0,128'h0,0,0);
    add(1,1,32'h12340004,0,1, 1,128'h12340004_12340003_12340002_12340001,0,0);
    add(1,0,32'h0,       0,1, 0,128'h0,0,0);
    // Overflow with a same-cycle word at cnt=0: word discarded, abort.
    add(1,1,32'hDEADDEAD,1,1, 0,128'h0,0,1);
    add(1,1,32'h00000001,0,1, 0,128'h0,0,0);
    add(1,1,32'h00000002,0,1, 0,128'h0,0,0);
    add(1,1,32'h00000003,0,1, 0,128'h0,0,0);
    add(1,1,32'h00000004,0,1, 1,128'h00000004_00000003_00000002_00000001,0,0);
    add(1,0,32'h0,       0,1, 0,128'h0,0,0);
    // Overflow with nothing pending: no abort.
    add(1,0,32'h0,       1,1, 0,128'h0,0,0);
    // Disable mid-flit: partial discarded, words ignored in IDLE.
    add(1,1,32'h5A5A0001,0,1, 0,128'h0,0,0);
    add(1,1,32'h5A5A0002,0,1, 0,128'h0,0,0);
    add(0,1,32'h5A5A0003,0,1, 0,128'h0,0,0);
    add(1,1,32'h5A5A0004,0,1, 0,128'h0,0,0);
    add(1,1,32'h00000061,0,1, 0,128'h0,0,0);
    add(1,1,32'h00000062,0,1, 0,128'h0,0,0);
    add(1,1,32'h00000063,0,1, 0,128'h0,0,0);
    add(1,1,32'h00000064,0,1, 1,128'h00000064_00000063_00000062_00000061,0,0);
    add(1,0,32'h0,       0,1, 0,128'h0,0,0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].vld, vecs[i].data, vecs[i].ovf,
                    vecs[i].rdy);
      checkOutput($sformatf("v%0d.valid", i), {127'h0, o_flit_valid},
                  {127'h0, vecs[i].exp_vld});
      checkOutput($sformatf("v%0d.drop", i), {127'h0, o_drop_err},
                  {127'h0, vecs[i].exp_drop});
      checkOutput($sformatf("v%0d.abort", i), {127'h0, o_abort},
                  {127'h0, vecs[i].exp_abort});
      if (vecs[i].exp_vld) begin
        checkOutput($sformatf("v%0d.data", i), o_flit_data, vecs[i].exp_data);
`ifdef UCIE_CTL_RX_PARITY_EN
        checkOutput($sformatf("v%0d.parity", i), {127'h0, o_parity_err},
                    {127'h0, flit_parity_bad(vecs[i].exp_data)});
`else
        checkOutput($sformatf("v%0d.parity", i), {127'h0, o_parity_err},
                    128'h0);
`endif
      end
    end

    // Reset mid-flit while a flit is held at the output.
    send_flit(128'h00000074_00000073_00000072_00000071, 1'b0);
    applyStimulus(1, 1, 32'h000000A1, 0, 0);
    applyStimulus(1, 1, 32'h000000A2, 0, 0);
    checkOutput("held.valid", {127'h0, o_flit_valid}, 128'h1);
    checkOutput("held.data", o_flit_data,
                128'h00000074_00000073_00000072_00000071);
    #2 i_rst = 1'b1;
    #1 check_all_zero("midrst");
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    check_all_zero("postrst");
    applyStimulus(1, 0, 32'h0, 0, 1);
    checkOutput("realign.idle", {127'h0, o_flit_valid}, 128'h0);
    send_flit(128'h00000084_00000083_00000082_00000081, 1'b1);
    checkOutput("realign.valid", {127'h0, o_flit_valid}, 128'h1);
    checkOutput("realign.data", o_flit_data,
                128'h00000084_00000083_00000082_00000081);
    applyStimulus(1, 0, 32'h0, 0, 1);
    checkOutput("realign.drain", {127'h0, o_flit_valid}, 128'h0);

`ifdef UCIE_CTL_RX_PARITY_EN
    // Good parity byte, then the same flit with one bit flipped.
    good = 128'h00ABCDEF_0A0B0C0D_10203040_01020304;
    p = 8'h00;
    for (int i = 0; i < 15; i++) p = p ^ good[i*8 +: 8];
    good[127:120] = p;
    bad = good ^ 128'h1;
    send_flit(good, 1'b1);
    checkOutput("par_good.valid", {127'h0, o_flit_valid}, 128'h1);
    checkOutput("par_good.data", o_flit_data, good);
    checkOutput("par_good.err", {127'h0, o_parity_err}, 128'h0);
    applyStimulus(1, 0, 32'h0, 0, 1);
    send_flit(bad, 1'b1);
    checkOutput("par_bad.valid", {127'h0, o_flit_valid}, 128'h1);
    checkOutput("par_bad.data", o_flit_data, bad);
    checkOutput("par_bad.err", {127'h0, o_parity_err}, 128'h1);
    applyStimulus(1, 0, 32'h0, 0, 1);
`else
    good = '0;
    bad  = '0;
    p    = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
